mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle MIPS control unit; sits directly upstream of the multicycle datapath.
//  Consumes op/funct/zero from the datapath and drives every datapath select/enable.
//  Main FSM, ALU decoder and PC-enable logic live here.
//  Adds a memory-ready stall handshake for FETCH/MEMRD/MEMWR.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: memready gates memory states; 0: memready ignored (treated as 1)
//  ENABLE_BNE     1  1: decode bne (op 000101); 0: bne is an illegal opcode
// PORTS
//  clk         in   1  single clock; all state changes on rising edge
//  reset       in   1  synchronous, active-low reset (0 = reset)
//  op          in   6  instr[31:26] from datapath
//  funct       in   6  instr[5:0] from datapath
//  zero        in   1  ALU zero flag from datapath
//  memready    in   1  memory access completes this cycle
//  pcen        out  1  PC register enable
//  irwrite     out  1  instruction register enable
//  regwrite    out  1  register file write enable
//  memwrite    out  1  memory write strobe
//  alusrca     out  1  0: PC, 1: A
//  iord        out  1  0: PC address, 1: ALUOut address
//  memtoreg    out  1  0: ALUOut, 1: Data
//  regdst      out  1  0: rt, 1: rd
//  alusrcb     out  2  00: B, 01: 4, 10: SignImm, 11: SignImm<<2
//  pcsrc       out  2  00: ALUResult, 01: ALUOut, 10: jump target
//  alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  illegal     out  1  one-cycle pulse on undecodable opcode
//  state       out  4  current FSM state (debug)
// BEHAVIOUR
//  - Reset: sampled at posedge while reset==0 -> state=FETCH(0).
//    While reset==0, all outputs are forced to 0.
//  - States/encoding:
//    FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5,
//    EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
//    Codes 12-15 go to FETCH.
//  - Moore outputs; any output not listed for a state is 0. aluop=00 unless listed.
//  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
//    irwrite=pcwrite=memready; stays in FETCH until memready=1, then DECODE.
//  - DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
//    100011/101011 -> MEMADR; 000000 -> EXEC; 000100/000101 -> BRANCH;
//    001000 -> ADDIEX; 000010 -> JUMP.
//    Any other op -> FETCH with illegal=1 for that cycle.
//  - MEMADR: alusrca=1, alusrcb=10. lw -> MEMRD, sw -> MEMWR.
//  - MEMRD: iord=1; hold until memready, then MEMWB.
//  - MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
//  - MEMWR: iord=1, memwrite=1 held every cycle until memready, then FETCH.
//  - EXEC: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
//    ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
//  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01 -> FETCH.
//    beq: branch when zero=1; bne: branch when zero=0.
//  - ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
//    ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
//  - JUMP: pcsrc=10, pcwrite=1 -> FETCH.
//  - pcen = pcwrite | (branch & (zero ^ isbne)). Combinational within the cycle.
//  - ALU decoder (combinational):
//    aluop 00 -> 010; aluop 01 -> 110;
//    aluop 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001,
//    101010->111, other funct -> 010.
//  - MEM_HANDSHAKE=0: FETCH/MEMRD/MEMWR each last exactly one cycle.
//  - Cycle counts with memready=1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
//  - Reset low mid-instruction: the next edge returns to FETCH.
//    No regwrite, memwrite or pcen is issued on that edge.
// TESTING
//  - reset=0 for 2 cycles, then 1 -> state=0, all strobes 0 during reset;
//    first FETCH shows alusrcb=01, irwrite=1, pcen=1.
//  - lw (op 100011), memready=1 -> states 0,1,2,3,4;
//    MEMWB has memtoreg=1, regwrite=1.
//  - sw in MEMWR with memready=0 for 3 cycles -> memwrite=1 for 4 cycles,
//    then state 0.
//  - R-type funct 101010 -> EXEC drives alucontrol=111; ALUWB drives regdst=1.
//  - beq zero=1 -> pcen=1, pcsrc=01. bne zero=1 -> pcen=0.
//    bne with ENABLE_BNE=0 -> illegal=1.
//  - op 111111 in DECODE -> illegal pulse, next state FETCH.
//    reset=0 during MEMWB -> no regwrite, state 0.

Source files
------------

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Brief    : Multicycle MIPS control FSM, ALU decoder and PC enable, with a
//            memory-ready stall on FETCH/MEMRD/MEMWR.
// Revision : 1.0
// ============================================================================
module mc_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ENABLE_BNE    = 1'b1
) (
    input  logic       clk,
    input  logic       i_reset,        // synchronous, active-low
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    input  logic       i_memready,
    output logic       o_pcen,
    output logic       o_irwrite,
    output logic       o_regwrite,
    output logic       o_memwrite,
    output logic       o_alusrca,
    output logic       o_iord,
    output logic       o_memtoreg,
    output logic       o_regdst,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_pcsrc,
    output logic [2:0] o_alucontrol,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       memwrite;
        logic       fetch;
        logic       jump;
        logic       branch;
    } ctrl_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    state_t     r_state;
    ctrl_t      r_ctrl;
    state_t     w_next;
    logic       w_decode_bad;
    logic       w_memready;
    logic       w_run;
    logic       w_pcwrite;
    logic       w_isbne;
    logic [2:0] w_alucontrol;

    // Moore control word for a state; registered alongside the state itself.
    function automatic ctrl_t f_decode(input state_t s);
        ctrl_t ctrl;
        ctrl = '0;
        case (s)
            S_FETCH:  begin ctrl.alusrcb = 2'b01; ctrl.fetch = 1'b1; end
            S_DECODE: ctrl.alusrcb = 2'b11;
            S_MEMADR: begin ctrl.alusrca = 1'b1; ctrl.alusrcb = 2'b10; end
            S_MEMRD:  ctrl.iord = 1'b1;
            S_MEMWB:  begin ctrl.memtoreg = 1'b1; ctrl.regwrite = 1'b1; end
            S_MEMWR:  begin ctrl.iord = 1'b1; ctrl.memwrite = 1'b1; end
            S_EXEC:   begin ctrl.alusrca = 1'b1; ctrl.aluop = 2'b10; end
            S_ALUWB:  begin ctrl.regdst = 1'b1; ctrl.regwrite = 1'b1; end
            S_BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = 2'b01;
                ctrl.pcsrc   = 2'b01;
                ctrl.branch  = 1'b1;
            end
            S_ADDIEX: begin ctrl.alusrca = 1'b1; ctrl.alusrcb = 2'b10; end
            S_ADDIWB: ctrl.regwrite = 1'b1;
            S_JUMP:   begin ctrl.pcsrc = 2'b10; ctrl.jump = 1'b1; end
            default:  ctrl = '0;
        endcase
        return ctrl;
    endfunction

    assign w_memready = MEM_HANDSHAKE ? i_memready : 1'b1;
    assign w_run      = i_reset;

    always_comb begin
        w_next       = S_FETCH;
        w_decode_bad = 1'b0;
        case (r_state)
            S_FETCH:  w_next = w_memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXEC;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_BNE: begin
                        if (ENABLE_BNE) w_next = S_BRANCH;
                        else            w_decode_bad = 1'b1;
                    end
                    c_OP_ADDI:        w_next = S_ADDIEX;
                    c_OP_J:           w_next = S_JUMP;
                    default:          w_decode_bad = 1'b1;
                endcase
            end
            S_MEMADR: w_next = (i_op == c_OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = w_memready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = w_memready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= f_decode(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_decode(w_next);
        end
    end

    always_comb begin
        w_alucontrol = 3'b010;
        case (r_ctrl.aluop)
            2'b01: w_alucontrol = 3'b110;
            2'b10: begin
                case (i_funct)
                    6'b100010: w_alucontrol = 3'b110;
                    6'b100100: w_alucontrol = 3'b000;
                    6'b100101: w_alucontrol = 3'b001;
                    6'b101010: w_alucontrol = 3'b111;
                    default:   w_alucontrol = 3'b010;
                endcase
            end
            default: w_alucontrol = 3'b010;
        endcase
    end

    // Holding reset low masks every output, so an interrupted write-back never commits.
    assign w_pcwrite    = (r_ctrl.fetch & w_memready) | r_ctrl.jump;
    assign w_isbne      = ENABLE_BNE & (i_op == c_OP_BNE);
    assign o_pcen       = w_run & (w_pcwrite | (r_ctrl.branch & (i_zero ^ w_isbne)));
    assign o_irwrite    = w_run & r_ctrl.fetch & w_memready;
    assign o_regwrite   = w_run & r_ctrl.regwrite;
    assign o_memwrite   = w_run & r_ctrl.memwrite;
    assign o_alusrca    = w_run & r_ctrl.alusrca;
    assign o_iord       = w_run & r_ctrl.iord;
    assign o_memtoreg   = w_run & r_ctrl.memtoreg;
    assign o_regdst     = w_run & r_ctrl.regdst;
    assign o_alusrcb    = w_run ? r_ctrl.alusrcb : 2'b00;
    assign o_pcsrc      = w_run ? r_ctrl.pcsrc : 2'b00;
    assign o_alucontrol = w_run ? w_alucontrol : 3'b000;
    assign o_illegal    = w_run & w_decode_bad;
    assign o_state      = w_run ? r_state : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// Testbench for mc_controller: directed vector table, then a random instruction
// stream checked against an instruction-level reference model.
module tb_mc_controller;

    localparam logic [5:0] c_LW   = 6'b100011;
    localparam logic [5:0] c_SW   = 6'b101011;
    localparam logic [5:0] c_RT   = 6'b000000;
    localparam logic [5:0] c_BEQ  = 6'b000100;
    localparam logic [5:0] c_BNE  = 6'b000101;
    localparam logic [5:0] c_ADDI = 6'b001000;
    localparam logic [5:0] c_J    = 6'b000010;
    localparam logic [5:0] c_BAD  = 6'b111111;
    localparam logic [5:0] c_SLT  = 6'b101010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op [2];
    logic [5:0] funct [2];
    logic       zero [2];
    logic       mr [2];
    logic       pcen [2];
    logic       irwrite [2];
    logic       regwrite [2];
    logic       memwrite [2];
    logic       alusrca [2];
    logic       iord [2];
    logic       memtoreg [2];
    logic       regdst [2];
    logic [1:0] alusrcb [2];
    logic [1:0] pcsrc [2];
    logic [2:0] alucontrol [2];
    logic       illegal [2];
    logic [3:0] state [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_controller #(.MEM_HANDSHAKE(1'b1), .ENABLE_BNE(1'b1)) u_dut0 (
        .clk(clk), .i_reset(rst_n), .i_op(op[0]), .i_funct(funct[0]),
        .i_zero(zero[0]), .i_memready(mr[0]),
        .o_pcen(pcen[0]), .o_irwrite(irwrite[0]), .o_regwrite(regwrite[0]),
        .o_memwrite(memwrite[0]), .o_alusrca(alusrca[0]), .o_iord(iord[0]),
        .o_memtoreg(memtoreg[0]), .o_regdst(regdst[0]), .o_alusrcb(alusrcb[0]),
        .o_pcsrc(pcsrc[0]), .o_alucontrol(alucontrol[0]), .o_illegal(illegal[0]),
        .o_state(state[0])
    );

    mc_controller #(.MEM_HANDSHAKE(1'b0), .ENABLE_BNE(1'b0)) u_dut1 (
        .clk(clk), .i_reset(rst_n), .i_op(op[1]), .i_funct(funct[1]),
        .i_zero(zero[1]), .i_memready(mr[1]),
        .o_pcen(pcen[1]), .o_irwrite(irwrite[1]), .o_regwrite(regwrite[1]),
        .o_memwrite(memwrite[1]), .o_alusrca(alusrca[1]), .o_iord(iord[1]),
        .o_memtoreg(memtoreg[1]), .o_regdst(regdst[1]), .o_alusrcb(alusrcb[1]),
        .o_pcsrc(pcsrc[1]), .o_alucontrol(alucontrol[1]), .o_illegal(illegal[1]),
        .o_state(state[1])
    );

    // Output vector layout: {pcen,irwrite,regwrite,memwrite,alusrca,iord,memtoreg,regdst,
    //                        alusrcb[1:0],pcsrc[1:0],alucontrol[2:0],illegal,state[3:0]}
    function automatic logic [19:0] P(input logic [7:0] flags, input logic [1:0] asb,
                                      input logic [1:0] pcs, input logic [2:0] alu,
                                      input logic ill, input logic [3:0] st);
        return {flags, asb, pcs, alu, ill, st};
    endfunction

    function automatic logic [19:0] get_out(input int d);
        return {pcen[d], irwrite[d], regwrite[d], memwrite[d], alusrca[d], iord[d],
                memtoreg[d], regdst[d], alusrcb[d], pcsrc[d], alucontrol[d],
                illegal[d], state[d]};
    endfunction

    task automatic check(input string name, input int d, input logic [19:0] exp);
        logic [19:0] got;
        got = get_out(d);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %b required %b", name, d, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [19:0] model_out(input int st, input logic mr_eff, input logic z,
                                              input logic bne, input logic [5:0] fn,
                                              input logic ill);
        logic take;
        take = bne ? ~z : z;
        case (st)
            0:  return P({mr_eff, mr_eff, 6'b000000}, 2'b01, 2'b00, 3'b010, 1'b0, 4'd0);
            1:  return P(8'b00000000, 2'b11, 2'b00, 3'b010, ill, 4'd1);
            2:  return P(8'b00001000, 2'b10, 2'b00, 3'b010, 1'b0, 4'd2);
            3:  return P(8'b00000100, 2'b00, 2'b00, 3'b010, 1'b0, 4'd3);
            4:  return P(8'b00100010, 2'b00, 2'b00, 3'b010, 1'b0, 4'd4);
            5:  return P(8'b00010100, 2'b00, 2'b00, 3'b010, 1'b0, 4'd5);
            6:  return P(8'b00001000, 2'b00, 2'b00, alu_of(fn), 1'b0, 4'd6);
            7:  return P(8'b00100001, 2'b00, 2'b00, 3'b010, 1'b0, 4'd7);
            8:  return P({take, 7'b0001000}, 2'b00, 2'b01, 3'b110, 1'b0, 4'd8);
            9:  return P(8'b00001000, 2'b10, 2'b00, 3'b010, 1'b0, 4'd9);
            10: return P(8'b00100000, 2'b00, 2'b00, 3'b010, 1'b0, 4'd10);
            11: return P(8'b10000000, 2'b00, 2'b10, 3'b010, 1'b0, 4'd11);
            default: return 20'h0;
        endcase
    endfunction

    typedef struct { logic z; logic mr; logic [19:0] exp; } cyc_t;
    cyc_t q[$];

    task automatic push(input int st, input logic mr_drv, input logic mr_eff,
                        input logic bne, input logic [5:0] fn, input logic ill);
        cyc_t c;
        c.z   = 1'($urandom);
        c.mr  = mr_drv;
        c.exp = model_out(st, mr_eff, c.z, bne, fn, ill);
        q.push_back(c);
    endtask

    // A memory phase: with the handshake, a random number of not-ready cycles first.
    task automatic push_mem(input int st, input bit hs, input logic [5:0] fn);
        int k;
        if (hs) begin
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) push(st, 1'b0, 1'b0, 1'b0, fn, 1'b0);
            push(st, 1'b1, 1'b1, 1'b0, fn, 1'b0);
        end else begin
            push(st, 1'($urandom), 1'b1, 1'b0, fn, 1'b0);
        end
    endtask

    task automatic do_reset(input int d);
        rst_n = 1'b0;
        #2;
        check("reset", d, 20'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic run_random(input int d, input int n_instr);
        bit hs, eb, ill;
        int kind;
        logic [5:0] o, fn;
        hs = (d == 0);
        eb = (d == 0);
        do_reset(d);
        for (int i = 0; i < n_instr; i++) begin
            q.delete();
            kind = $urandom_range(0, 7);
            fn   = 6'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 4))
                    0: fn = 6'b100000;
                    1: fn = 6'b100010;
                    2: fn = 6'b100100;
                    3: fn = 6'b100101;
                    default: fn = 6'b101010;
                endcase
            end
            case (kind)
                0: o = c_LW;
                1: o = c_SW;
                2: o = c_RT;
                3: o = c_BEQ;
                4: o = c_BNE;
                5: o = c_ADDI;
                6: o = c_J;
                default: begin
                    do o = 6'($urandom);
                    while (o == c_LW || o == c_SW || o == c_RT || o == c_BEQ ||
                           o == c_BNE || o == c_ADDI || o == c_J);
                end
            endcase
            ill = (kind == 7) || (kind == 4 && !eb);
            push_mem(0, hs, fn);
            push(1, 1'($urandom), 1'b1, 1'b0, fn, ill);
            if (!ill) begin
                case (kind)
                    0: begin
                        push(2, 1'($urandom), 1'b1, 1'b0, fn, 1'b0);
                        push_mem(3, hs, fn);
                        push(4, 1'($urandom), 1'b1, 1'b0, fn, 1'b0);
                    end
                    1: begin
                        push(2, 1'($urandom), 1'b1, 1'b0, fn, 1'b0);
                        push_mem(5, hs, fn);
                    end
                    2: begin
                        push(6, 1'($urandom), 1'b1, 1'b0, fn, 1'b0);
                        push(7, 1'($urandom), 1'b1, 1'b0, fn, 1'b0);
                    end
                    3: push(8, 1'($urandom), 1'b1, 1'b0, fn, 1'b0);
                    4: push(8, 1'($urandom), 1'b1, 1'b1, fn, 1'b0);
                    5: begin
                        push(9, 1'($urandom), 1'b1, 1'b0, fn, 1'b0);
                        push(10, 1'($urandom), 1'b1, 1'b0, fn, 1'b0);
                    end
                    default: push(11, 1'($urandom), 1'b1, 1'b0, fn, 1'b0);
                endcase
            end
            op[d]    = o;
            funct[d] = fn;
            for (int k = 0; k < q.size(); k++) begin
                zero[d] = q[k].z;
                mr[d]   = q[k].mr;
                #2;
                check($sformatf("rand op=%b cyc%0d", o, k), d, q[k].exp);
                @(posedge clk); #1;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          d;
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        mr;
        logic [19:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic v(input int d, input logic rst, input logic [5:0] o, input logic [5:0] fn,
                     input logic z, input logic m, input logic [19:0] exp);
        vec_t e;
        e.d = d; e.rst = rst; e.op = o; e.fn = fn; e.z = z; e.mr = m; e.exp = exp;
        tbl.push_back(e);
    endtask

    logic [19:0] eF, eFS, eD, eDB, eMA, eMR, eMB, eMW, eEX, eAW, eBT, eBN, eAX, eAB, eJ;

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            op[d] = 6'd0; funct[d] = 6'd0; zero[d] = 1'b0; mr[d] = 1'b0;
        end

        eF  = P(8'b11000000, 2'b01, 2'b00, 3'b010, 1'b0, 4'd0);
        eFS = P(8'b00000000, 2'b01, 2'b00, 3'b010, 1'b0, 4'd0);
        eD  = P(8'b00000000, 2'b11, 2'b00, 3'b010, 1'b0, 4'd1);
        eDB = P(8'b00000000, 2'b11, 2'b00, 3'b010, 1'b1, 4'd1);
        eMA = P(8'b00001000, 2'b10, 2'b00, 3'b010, 1'b0, 4'd2);
        eMR = P(8'b00000100, 2'b00, 2'b00, 3'b010, 1'b0, 4'd3);
        eMB = P(8'b00100010, 2'b00, 2'b00, 3'b010, 1'b0, 4'd4);
        eMW = P(8'b00010100, 2'b00, 2'b00, 3'b010, 1'b0, 4'd5);
        eEX = P(8'b00001000, 2'b00, 2'b00, 3'b111, 1'b0, 4'd6);
        eAW = P(8'b00100001, 2'b00, 2'b00, 3'b010, 1'b0, 4'd7);
        eBT = P(8'b10001000, 2'b00, 2'b01, 3'b110, 1'b0, 4'd8);
        eBN = P(8'b00001000, 2'b00, 2'b01, 3'b110, 1'b0, 4'd8);
        eAX = P(8'b00001000, 2'b10, 2'b00, 3'b010, 1'b0, 4'd9);
        eAB = P(8'b00100000, 2'b00, 2'b00, 3'b010, 1'b0, 4'd10);
        eJ  = P(8'b10000000, 2'b00, 2'b10, 3'b010, 1'b0, 4'd11);

        // Handshake DUT: reset, lw, stalled sw, slt, beq/bne, addi, j, illegal,
        // stalled fetch/memrd, reset during MEMWB.
        v(0, 1'b0, c_LW, 6'd0, 1'b0, 1'b1, 20'h0);
        v(0, 1'b0, c_LW, 6'd0, 1'b0, 1'b1, 20'h0);
        v(0, 1'b1, c_LW, 6'd0, 1'b0, 1'b1, eF);
        v(0, 1'b1, c_LW, 6'd0, 1'b0, 1'b1, eD);
        v(0, 1'b1, c_LW, 6'd0, 1'b0, 1'b1, eMA);
        v(0, 1'b1, c_LW, 6'd0, 1'b0, 1'b1, eMR);
        v(0, 1'b1, c_LW, 6'd0, 1'b0, 1'b1, eMB);
        v(0, 1'b1, c_SW, 6'd0, 1'b0, 1'b1, eF);
        v(0, 1'b1, c_SW, 6'd0, 1'b0, 1'b1, eD);
        v(0, 1'b1, c_SW, 6'd0, 1'b0, 1'b1, eMA);
        v(0, 1'b1, c_SW, 6'd0, 1'b0, 1'b0, eMW);
        v(0, 1'b1, c_SW, 6'd0, 1'b0, 1'b0, eMW);
        v(0, 1'b1, c_SW, 6'd0, 1'b0, 1'b0, eMW);
        v(0, 1'b1, c_SW, 6'd0, 1'b0, 1'b1, eMW);
        v(0, 1'b1, c_RT, c_SLT, 1'b0, 1'b1, eF);
        v(0, 1'b1, c_RT, c_SLT, 1'b0, 1'b1, eD);
        v(0, 1'b1, c_RT, c_SLT, 1'b0, 1'b1, eEX);
        v(0, 1'b1, c_RT, c_SLT, 1'b0, 1'b1, eAW);
        v(0, 1'b1, c_BEQ, 6'd0, 1'b1, 1'b1, eF);
        v(0, 1'b1, c_BEQ, 6'd0, 1'b1, 1'b1, eD);
        v(0, 1'b1, c_BEQ, 6'd0, 1'b1, 1'b1, eBT);
        v(0, 1'b1, c_BEQ, 6'd0, 1'b0, 1'b1, eF);
        v(0, 1'b1, c_BEQ, 6'd0, 1'b0, 1'b1, eD);
        v(0, 1'b1, c_BEQ, 6'd0, 1'b0, 1'b1, eBN);
        v(0, 1'b1, c_BNE, 6'd0, 1'b1, 1'b1, eF);
        v(0, 1'b1, c_BNE, 6'd0, 1'b1, 1'b1, eD);
        v(0, 1'b1, c_BNE, 6'd0, 1'b1, 1'b1, eBN);
        v(0, 1'b1, c_ADDI, 6'd0, 1'b0, 1'b1, eF);
        v(0, 1'b1, c_ADDI, 6'd0, 1'b0, 1'b1, eD);
        v(0, 1'b1, c_ADDI, 6'd0, 1'b0, 1'b1, eAX);
        v(0, 1'b1, c_ADDI, 6'd0, 1'b0, 1'b1, eAB);
        v(0, 1'b1, c_J, 6'd0, 1'b0, 1'b1, eF);
        v(0, 1'b1, c_J, 6'd0, 1'b0, 1'b1, eD);
        v(0, 1'b1, c_J, 6'd0, 1'b0, 1'b1, eJ);
        v(0, 1'b1, c_BAD, 6'd0, 1'b0, 1'b1, eF);
        v(0, 1'b1, c_BAD, 6'd0, 1'b0, 1'b1, eDB);
        v(0, 1'b1, c_LW, 6'd0, 1'b0, 1'b0, eFS);
        v(0, 1'b1, c_LW, 6'd0, 1'b0, 1'b1, eF);
        v(0, 1'b1, c_LW, 6'd0, 1'b0, 1'b1, eD);
        v(0, 1'b1, c_LW, 6'd0, 1'b0, 1'b1, eMA);
        v(0, 1'b1, c_LW, 6'd0, 1'b0, 1'b0, eMR);
        v(0, 1'b1, c_LW, 6'd0, 1'b0, 1'b1, eMR);
        v(0, 1'b0, c_LW, 6'd0, 1'b0, 1'b1, 20'h0);
        v(0, 1'b1, c_LW, 6'd0, 1'b0, 1'b1, eF);
        // No-handshake, bne-disabled DUT.
        v(1, 1'b0, c_BNE, 6'd0, 1'b0, 1'b0, 20'h0);
        v(1, 1'b1, c_BNE, 6'd0, 1'b0, 1'b0, eF);
        v(1, 1'b1, c_BNE, 6'd0, 1'b0, 1'b0, eDB);
        v(1, 1'b1, c_LW, 6'd0, 1'b0, 1'b0, eF);
        v(1, 1'b1, c_LW, 6'd0, 1'b0, 1'b0, eD);
        v(1, 1'b1, c_LW, 6'd0, 1'b0, 1'b0, eMA);
        v(1, 1'b1, c_LW, 6'd0, 1'b0, 1'b0, eMR);
        v(1, 1'b1, c_LW, 6'd0, 1'b0, 1'b0, eMB);
        v(1, 1'b1, c_SW, 6'd0, 1'b0, 1'b0, eF);
        v(1, 1'b1, c_SW, 6'd0, 1'b0, 1'b0, eD);
        v(1, 1'b1, c_SW, 6'd0, 1'b0, 1'b0, eMA);
        v(1, 1'b1, c_SW, 6'd0, 1'b0, 1'b0, eMW);
        v(1, 1'b1, c_SW, 6'd0, 1'b0, 1'b0, eF);

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst_n               = tbl[i].rst;
            op[tbl[i].d]        = tbl[i].op;
            funct[tbl[i].d]     = tbl[i].fn;
            zero[tbl[i].d]      = tbl[i].z;
            mr[tbl[i].d]        = tbl[i].mr;
            #2;
            check($sformatf("vec%0d", i), tbl[i].d, tbl[i].exp);
            @(posedge clk); #1;
        end

        run_random(0, 200);
        run_random(1, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
